// File: rtl/rv32i_types.sv
// Shared RV32I datapath types, plus the state encoding of the memory word bridge.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } mem_bridge_state_t;

    localparam rv32i_mem_wmask FULL_WORD_MASK = 4'b1111;
    localparam rv32i_word      WORD_ALIGN     = 32'hFFFF_FFFC;

endpackage

// File: rtl/byte_merge.sv
// Byte-lane merge: combines a masked new word into an existing word.
// Kept generic so a future cache can reuse it for its own write path.
module byte_merge
    import rv32i_types::*;
(
    input  rv32i_mem_wmask mask,
    input  rv32i_word      new_word,
    input  rv32i_word      old_word,
    output rv32i_word      merged
);

    // Each lane takes the new byte where its mask bit is set, else keeps the old byte
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_word_bridge.sv
// Bridge from the core's byte-masked memory request to a word-only physical
// port. Partial stores become a read-modify-write; every physical access is
// bounded by a watchdog that sets a sticky error when it expires.
module mem_word_bridge
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mem_bridge_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              timed_out;
    rv32i_word         addr_q, addr_d;
    rv32i_word         wdata_q, wdata_d;
    rv32i_mem_wmask    mask_q, mask_d;
    rv32i_word         rdata_q, rdata_d;
    logic              err_q, err_d;
    rv32i_word         merged;

    // Merge the latched store bytes over the word returned by the RMW read
    byte_merge u_byte_merge (
        .mask     (mask_q),
        .new_word (wdata_q),
        .old_word (pmem_rdata),
        .merged   (merged)
    );

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched request, write word, read data, watchdog, error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath updates; the watchdog fires when it would reach the limit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_inc   = cnt_q + CNT_W'(1);
        timed_out = (cnt_inc == CNT_LIMIT);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_read) begin
                    addr_d  = mem_address & WORD_ALIGN;
                    rdata_d = '0;
                    state_d = RD;
                end else if (mem_write) begin
                    rdata_d = '0;
                    if (mem_byte_enable == 4'b0000) begin
                        state_d = RESP;
                    end else begin
                        addr_d  = mem_address & WORD_ALIGN;
                        wdata_d = mem_wdata;
                        mask_d  = mem_byte_enable;
                        state_d = (mem_byte_enable == FULL_WORD_MASK) ? WR : RMW_RD;
                    end
                end
            end
            RD: begin
                if (pmem_resp) begin
                    rdata_d = pmem_rdata;
                    state_d = RESP;
                end else if (timed_out) begin
                    cnt_d   = cnt_inc;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RMW_RD: begin
                if (pmem_resp) begin
                    wdata_d = merged;
                    cnt_d   = '0;
                    state_d = WR;
                end else if (timed_out) begin
                    cnt_d   = cnt_inc;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WR: begin
                if (pmem_resp) begin
                    state_d = RESP;
                end else if (timed_out) begin
                    cnt_d   = cnt_inc;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pmem_read    = (state_q == RD) || (state_q == RMW_RD);
    assign pmem_write   = (state_q == WR);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign mem_resp     = (state_q == RESP);
    assign mem_rdata    = (state_q == RESP) ? rdata_q : '0;
    assign err          = err_q;

endmodule

// File: tb/tb_mem_word_bridge.sv
// Randomised self-checking bench for mem_word_bridge with a word-level
// memory reference model and a per-cycle expected-output timeline.
module tb_mem_word_bridge;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;
    logic        err;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          resp;
        logic [31:0] addr;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int          wait_q[$];
    logic [31:0] phys_mem [64];
    logic [31:0] ref_mem  [64];
    bit          model_err;
    bit          compare_on;
    logic [31:0] last_rdata;
    int          checks;
    int          failures;

    mem_word_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .err             (err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit rd, input bit wr, input bit resp,
                            input logic [31:0] addr, input logic [31:0] rdata, input bit e_err);
        exp_t e;
        e.rd = rd; e.wr = wr; e.resp = resp; e.addr = addr; e.rdata = rdata; e.err = e_err;
        exp_q.push_back(e);
    endtask

    // Physical memory: each access answers after its queued wait count (-1 never answers)
    initial begin
        bit busy;
        int cnt;
        int cur_w;
        busy = 0; cnt = 0; cur_w = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                busy = 0;
            end
            if (busy && !(pmem_read || pmem_write)) busy = 0;
            if (!busy && (pmem_read || pmem_write)) begin
                busy = 1;
                cnt = 0;
                cur_w = (wait_q.size() > 0) ? wait_q.pop_front() : -1;
            end
            pmem_rdata = $urandom;
            if (busy && cur_w >= 0) begin
                if (cnt == cur_w) begin
                    pmem_resp = 1'b1;
                    if (pmem_read) pmem_rdata = phys_mem[pmem_address[7:2]];
                    else phys_mem[pmem_address[7:2]] = pmem_wdata;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the expected timeline
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (compare_on) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.rd = 0; e.wr = 0; e.resp = 0; e.addr = '0; e.rdata = '0; e.err = model_err;
            end
            check_output("pmem_read", 32'(pmem_read), 32'(e.rd));
            check_output("pmem_write", 32'(pmem_write), 32'(e.wr));
            check_output("mem_resp", 32'(mem_resp), 32'(e.resp));
            check_output("err", 32'(err), 32'(e.err));
            if (e.rd || e.wr) check_output("pmem_address", pmem_address, e.addr);
            if (e.resp) begin
                check_output("mem_rdata", mem_rdata, e.rdata);
                last_rdata = mem_rdata;
            end
        end
    end

    // One core request: build the expected timeline from the memory model, then drive it
    task automatic apply_stimulus(input bit is_write, input logic [31:0] addr, input logic [3:0] mask,
                                  input logic [31:0] wdata, input int w1, input int w2,
                                  output int resp_cycle, output int rd_cycles, output int wr_cycles);
        int          idx;
        int          n;
        bit          err_before;
        logic [31:0] waddr;
        logic [31:0] word;
        @(negedge clk);
        idx = int'(addr[7:2]);
        waddr = {addr[31:2], 2'b00};
        err_before = model_err;
        wait_q.delete();
        if (!is_write) begin
            wait_q.push_back(w1);
            if (w1 < 0) begin
                repeat (TIMEOUT) push_exp(1, 0, 0, waddr, 0, err_before);
                model_err = 1;
                push_exp(0, 0, 1, 0, 0, 1);
            end else begin
                repeat (w1 + 1) push_exp(1, 0, 0, waddr, 0, err_before);
                push_exp(0, 0, 1, 0, ref_mem[idx], err_before);
            end
        end else if (mask == 4'b0000) begin
            push_exp(0, 0, 1, 0, 0, err_before);
        end else if (mask == 4'b1111) begin
            wait_q.push_back(w1);
            if (w1 < 0) begin
                repeat (TIMEOUT) push_exp(0, 1, 0, waddr, 0, err_before);
                model_err = 1;
                push_exp(0, 0, 1, 0, 0, 1);
            end else begin
                repeat (w1 + 1) push_exp(0, 1, 0, waddr, 0, err_before);
                push_exp(0, 0, 1, 0, 0, err_before);
                ref_mem[idx] = wdata;
            end
        end else begin
            wait_q.push_back(w1);
            if (w1 < 0) begin
                repeat (TIMEOUT) push_exp(1, 0, 0, waddr, 0, err_before);
                model_err = 1;
                push_exp(0, 0, 1, 0, 0, 1);
            end else begin
                wait_q.push_back(w2);
                repeat (w1 + 1) push_exp(1, 0, 0, waddr, 0, err_before);
                if (w2 < 0) begin
                    repeat (TIMEOUT) push_exp(0, 1, 0, waddr, 0, err_before);
                    model_err = 1;
                    push_exp(0, 0, 1, 0, 0, 1);
                end else begin
                    repeat (w2 + 1) push_exp(0, 1, 0, waddr, 0, err_before);
                    push_exp(0, 0, 1, 0, 0, err_before);
                    word = ref_mem[idx];
                    for (int i = 0; i < 4; i++) if (mask[i]) word[8*i +: 8] = wdata[8*i +: 8];
                    ref_mem[idx] = word;
                end
            end
        end
        n = exp_q.size();
        mem_read = !is_write;
        mem_write = is_write;
        mem_address = addr;
        mem_byte_enable = mask;
        mem_wdata = wdata;
        resp_cycle = 0; rd_cycles = 0; wr_cycles = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (pmem_read) rd_cycles++;
            if (pmem_write) wr_cycles++;
            if (mem_resp && resp_cycle == 0) resp_cycle = c;
            if (c == n) begin
                mem_read = 1'b0;
                mem_write = 1'b0;
            end else begin
                mem_address = $urandom;
                mem_wdata = $urandom;
                mem_byte_enable = 4'($urandom);
            end
        end
        if (is_write) check_output("mem_word", phys_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int rc, rdc, wrc;
        logic [31:0] saved;
        checks = 0; failures = 0;
        model_err = 0; compare_on = 0; last_rdata = '0;
        rst_n = 1'b0;
        mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
        for (int i = 0; i < 64; i++) begin
            phys_mem[i] = $urandom;
            ref_mem[i] = phys_mem[i];
        end
        phys_mem[24] = 32'h12345678; ref_mem[24] = 32'h12345678;
        phys_mem[26] = 32'hCAFEF00D; ref_mem[26] = 32'hCAFEF00D;

        #12;
        check_output("reset_outputs", {mem_rdata | pmem_address | pmem_wdata},
                     32'h0);
        check_output("reset_strobes", {28'h0, mem_resp, pmem_read, pmem_write, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_on = 1;

        // LW 0x60, W=2
        apply_stimulus(0, 32'h60, 4'hF, 0, 2, 0, rc, rdc, wrc);
        check_output("lw_resp_cycle", rc, 4);
        check_output("lw_rdata", last_rdata, 32'h12345678);
        // SW 0x64 full word
        apply_stimulus(1, 32'h64, 4'hF, 32'hAABBCCDD, 1, 0, rc, rdc, wrc);
        check_output("sw_no_read", rdc, 0);
        check_output("sw_word", phys_mem[25], 32'hAABBCCDD);
        // SB 0x66 over 0x11223344
        phys_mem[25] = 32'h11223344; ref_mem[25] = 32'h11223344;
        apply_stimulus(1, 32'h66, 4'b0100, 32'h00EE0000, 1, 2, rc, rdc, wrc);
        check_output("sb_word", phys_mem[25], 32'h11EE3344);
        check_output("sb_resp_cycle", rc, 6);
        // SH 0x67 mask 1100
        apply_stimulus(1, 32'h67, 4'b1100, 32'h55660000, 0, 0, rc, rdc, wrc);
        check_output("sh_low_bytes", {16'h0, phys_mem[25][15:0]}, 32'h3344);
        check_output("sh_word", phys_mem[25], 32'h55663344);
        // Response on the last allowed cycle still wins over the watchdog
        apply_stimulus(0, 32'h60, 4'h0, 0, TIMEOUT - 1, 0, rc, rdc, wrc);
        check_output("late_rdata", last_rdata, 32'h12345678);
        check_output("late_err", 32'(err), 0);
        // Mask 0000 write
        apply_stimulus(1, 32'h64, 4'b0000, 32'hFFFFFFFF, 0, 0, rc, rdc, wrc);
        check_output("zero_mask_resp", rc, 1);
        // Silent pmem on LW
        apply_stimulus(0, 32'h60, 4'h0, 0, -1, 0, rc, rdc, wrc);
        check_output("timeout_rd_cycles", rdc, TIMEOUT);
        check_output("timeout_rdata", last_rdata, 0);
        check_output("timeout_err", 32'(err), 1);
        apply_stimulus(0, 32'h68, 4'h0, 0, 1, 0, rc, rdc, wrc);
        check_output("after_timeout_rdata", last_rdata, 32'hCAFEF00D);
        check_output("after_timeout_err", 32'(err), 1);

        // Reset while the write phase of an RMW is pending
        @(negedge clk);
        compare_on = 0;
        saved = phys_mem[26];
        wait_q.delete();
        wait_q.push_back(0);
        wait_q.push_back(-1);
        mem_write = 1; mem_address = 32'h69; mem_byte_enable = 4'b0010; mem_wdata = 32'h0000AB00;
        repeat (3) @(negedge clk);
        check_output("rmw_in_write", 32'(pmem_write), 1);
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_data_outputs", mem_rdata | pmem_address | pmem_wdata, 0);
        check_output("rst_strobes", {28'h0, mem_resp, pmem_read, pmem_write, err}, 0);
        mem_write = 0;
        wait_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_err = 0;
        compare_on = 1;
        check_output("abandoned_write", phys_mem[26], saved);
        apply_stimulus(1, 32'h70, 4'hF, 32'h0BADBEEF, 1, 0, rc, rdc, wrc);
        check_output("post_reset_sw", phys_mem[28], 32'h0BADBEEF);
        check_output("post_reset_resp", rc, 3);

        // Randomised traffic
        for (int t = 0; t < 120; t++) begin
            bit          is_w;
            int          mode, w1, w2;
            logic [3:0]  mask;
            logic [31:0] addr;
            is_w = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            mask = (mode == 0) ? 4'hF : (mode == 1) ? 4'h0 : 4'($urandom);
            addr = 32'($urandom_range(0, 255));
            w1 = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
            w2 = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
            apply_stimulus(is_w, addr, mask, $urandom, w1, w2, rc, rdc, wrc);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_word_bridge.md
# mem_word_bridge

Sits between the multicycle RV32I control/datapath and physical memory. It consumes the core's `mem_read`/`mem_write`/`mem_byte_enable` request, which is held until `mem_resp`, and drives a word-only physical port. The physical port supports only full-word writes, so partial-byte stores are turned into an internal read-modify-write. A watchdog bounds every physical access and raises a sticky error when it expires.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent waiting for `pmem_resp` in any one pmem state.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  core read request, held until `mem_resp`.
- `mem_write`  in  1  core write request, held until `mem_resp`.
- `mem_byte_enable`  in  4  write byte mask (`rv32i_mem_wmask`).
- `mem_address`  in  32  byte address.
- `mem_wdata`  in  32  write data, already lane-aligned.
- `mem_rdata`  out  32  read data, valid while `mem_resp`=1.
- `mem_resp`  out  1  one-cycle completion pulse.
- `pmem_read`  out  1  physical read strobe, held until `pmem_resp`.
- `pmem_write`  out  1  physical full-word write strobe, held until `pmem_resp`.
- `pmem_address`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `pmem_wdata`  out  32  physical write word.
- `pmem_rdata`  in  32  physical read word, valid with `pmem_resp`.
- `pmem_resp`  in  1  physical completion.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
States: `IDLE`, `RD`, `RMW_RD`, `WR`, `RESP`.

- **IDLE**
  - On `mem_read`, latch the address and go to `RD`. Read has priority if both `mem_read` and `mem_write` are high.
  - On `mem_write` with mask 1111, latch address, data and mask, and go to `WR`.
  - On `mem_write` with any other nonzero mask, latch the same fields and go to `RMW_RD`.
  - On `mem_write` with mask 0000, go straight to `RESP` with no pmem access.
- **RD**
  - Assert `pmem_read`.
  - On `pmem_resp`, capture `pmem_rdata` into the rdata register and go to `RESP`.
- **RMW_RD**
  - Assert `pmem_read`.
  - On `pmem_resp`, form the merged word: byte i comes from latched `wdata` if mask[i]=1, otherwise from `pmem_rdata`. Register it, then go to `WR`.
- **WR**
  - Assert `pmem_write` with `pmem_wdata` set to the latched word (full store) or the merged word (partial store).
  - On `pmem_resp`, go to `RESP`.
- **RESP**
  - Assert `mem_resp` for one cycle, driving the rdata register (0 for writes), then go to `IDLE`.
- **Request handling**
  - Latched request fields are used throughout. Upstream changes after the latch are ignored.
  - `mem_read`/`mem_write` sampled in the cycle right after `RESP` are a new request. The core never re-asserts there.
- **Watchdog**
  - The counter clears on entry to `RD`, `RMW_RD` and `WR`.
  - If it reaches `TIMEOUT_CYCLES` without `pmem_resp`: drop the strobe, set `err`, clear the rdata register to 0, go to `RESP`, and skip the write phase of an RMW.
- `pmem_resp` in `IDLE` or `RESP` is ignored.

## Timing
- All outputs are Moore-decoded from registered state and datapath registers; no input-to-output combinational path.
- Reset values: state `IDLE`; `mem_resp`=0, `mem_rdata`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `err`=0, watchdog counter=0.
- Reset mid-operation: the strobes drop asynchronously and the in-flight access is abandoned.
- Let a request first be sampled high at the edge ending cycle 0, and let each pmem access complete after W wait cycles (`pmem_resp` high in its (W+1)th cycle).
  - Read: `pmem_read` asserted in cycles 1..1+W; `mem_resp` in cycle 2+W.
  - Full write: same timing as a read, using `pmem_write`.
  - Partial write: `pmem_read` in cycles 1..1+W1, `pmem_write` in cycles 2+W1..2+W1+W2, `mem_resp` in cycle 3+W1+W2.
  - Mask-0000 write: `mem_resp` in cycle 1.
- `pmem_address` is stable for the whole access, including across both RMW phases.

## Structure
- From `rv32i_types`: `rv32i_word` and `rv32i_mem_wmask`.
- Add `mem_bridge_state_t` (the state enum) to `rv32i_types`.
- One combinational sub-module, `byte_merge` (mask, new word, old word → merged word), reused by any future cache.
- Watchdog counter width: `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- LW at 0x00000060, pmem returns 0x12345678 with W=2 → `pmem_address`=0x60, `mem_rdata`=0x12345678, `mem_resp` high only in cycle 4.
- SW at 0x64, mask 1111, data 0xAABBCCDD → single `pmem_write` with 0xAABBCCDD; `pmem_read` never asserted.
- SB at 0x66, mask 0100, data 0x00EE0000, memory word 0x11223344 → read, then write 0x11EE3344 at 0x64.
- SH at 0x67 with mask 1100 → `pmem_address`=0x64 in both phases; bytes 0–1 of memory unchanged.
- `TIMEOUT_CYCLES`=8, pmem silent on LW → `pmem_read` high exactly 8 cycles, then `err`=1 and `mem_resp` with `mem_rdata`=0. A following LW succeeds with `err` still 1.
- `rst_n` low during `WR` of an RMW → all outputs 0 immediately; a subsequent SW at 0x70 completes normally.
